// File: rtl/eth_mdio_master.sv
// -----------------------------------------------------------------------------
// eth_mdio_master
//
// Clause-22 MDIO management master. Each accepted request is turned into one
// complete management frame on phy_mdc / phy_mdio_*. The frame consists of an
// optional 32-bit all-ones preamble, then ST, OP, PHYAD, REGAD, TA and DATA.
// Read data is shifted in from phy_mdio_i and reported with a one-cycle
// rsp_valid pulse.
//
// Parameters
//   CLK_DIV      msoc_clk cycles per MDC half-period (2..255)
//   PREAMBLE_EN  1 = send the 32-bit preamble, 0 = start directly with ST
//
// Ports
//   msoc_clk      sole clock, rising-edge
//   rstn          asynchronous active-low reset
//   req_valid     request strobe, accepted when req_ready is high
//   req_ready     high while idle
//   req_write     1 = write frame, 0 = read frame
//   req_phyad     PHY address (5 bits)
//   req_regad     register address (5 bits)
//   req_wdata     write data (16 bits)
//   rsp_valid     one-cycle completion pulse
//   rsp_rdata     read data (0 for writes), held until the next rsp_valid
//   rsp_err       read turnaround not driven low by the PHY, held likewise
//   busy          frame in progress (complement of req_ready)
//   phy_mdc       management clock
//   phy_mdio_o    MDIO drive value
//   phy_mdio_oen  1 = drive the MDIO pad, 0 = released
//   phy_mdio_i    MDIO pad input (already synchronised)
// -----------------------------------------------------------------------------
module eth_mdio_master #(
    parameter int unsigned CLK_DIV     = 20,
    parameter bit          PREAMBLE_EN = 1'b1
) (
    input  logic        msoc_clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phyad,
    input  logic [4:0]  req_regad,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        phy_mdc,
    output logic        phy_mdio_o,
    output logic        phy_mdio_oen,
    input  logic        phy_mdio_i
);

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA,
        DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    // Control state (reset)
    state_t      state;
    state_t      state_nxt;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_cnt_nxt;
    logic [7:0]  div_cnt;
    logic [7:0]  div_cnt_nxt;
    logic        mdc_nxt;
    logic        mdio_o_nxt;
    logic        mdio_oen_nxt;
    logic        rsp_valid_nxt;
    logic [15:0] rsp_rdata_nxt;
    logic        rsp_err_nxt;

    // Captured request and read accumulation (data, no reset)
    logic        wr_q;
    logic        wr_nxt;
    logic [4:0]  phyad_q;
    logic [4:0]  phyad_nxt;
    logic [4:0]  regad_q;
    logic [4:0]  regad_nxt;
    logic [15:0] wdata_q;
    logic [15:0] wdata_nxt;
    logic [15:0] rd_sr;
    logic [15:0] rd_sr_nxt;
    logic        ta_err;
    logic        ta_err_nxt;

    // Index of the final bit period of each frame field.
    function automatic logic [5:0] last_bit(input state_t s);
        case (s)
            PRE:          return 6'd31;
            PHYAD, REGAD: return 6'd4;
            DATA:         return 6'd15;
            default:      return 6'd1;
        endcase
    endfunction

    // Field that follows s in the frame.
    function automatic state_t next_field(input state_t s);
        case (s)
            PRE:     return ST;
            ST:      return OP;
            OP:      return PHYAD;
            PHYAD:   return REGAD;
            REGAD:   return TA;
            TA:      return DATA;
            DATA:    return DONE;
            default: return IDLE;
        endcase
    endfunction

    // Pad drive {oen, o} for bit cnt of field s. Fields are sent MSB first,
    // so the current bit is the MSB after shifting left by cnt. On reads the
    // pad is released from the first turnaround bit onwards.
    function automatic logic [1:0] drive_bit(
        input state_t      s,
        input logic [3:0]  cnt,
        input logic        wr,
        input logic [4:0]  phyad,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        logic [4:0]  pa_sh;
        logic [4:0]  ra_sh;
        logic [15:0] wd_sh;
        pa_sh = phyad << cnt[2:0];
        ra_sh = regad << cnt[2:0];
        wd_sh = wdata << cnt;
        case (s)
            PRE:     return 2'b11;
            ST:      return {1'b1, cnt[0]};
            OP:      return {1'b1, wr ? cnt[0] : ~cnt[0]};
            PHYAD:   return {1'b1, pa_sh[4]};
            REGAD:   return {1'b1, ra_sh[4]};
            TA:      return wr ? {1'b1, ~cnt[0]} : 2'b01;
            DATA:    return wr ? {1'b1, wd_sh[15]} : 2'b01;
            default: return 2'b01;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        div_cnt_nxt   = div_cnt;
        mdc_nxt       = phy_mdc;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        wr_nxt        = wr_q;
        phyad_nxt     = phyad_q;
        regad_nxt     = regad_q;
        wdata_nxt     = wdata_q;
        rd_sr_nxt     = rd_sr;
        ta_err_nxt    = ta_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    wr_nxt      = req_write;
                    phyad_nxt   = req_phyad;
                    regad_nxt   = req_regad;
                    wdata_nxt   = req_wdata;
                    rd_sr_nxt   = 16'h0000;
                    ta_err_nxt  = 1'b0;
                    bit_cnt_nxt = 6'd0;
                    div_cnt_nxt = 8'd0;
                    mdc_nxt     = 1'b0;
                    state_nxt   = PREAMBLE_EN ? PRE : ST;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                // Divider: CLK_DIV cycles MDC low, CLK_DIV cycles MDC high,
                // then the bit period ends and the next bit starts.
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = 8'd0;
                    if (!phy_mdc) begin
                        mdc_nxt = 1'b1;
                    end else begin
                        mdc_nxt = 1'b0;
                        if (bit_cnt == last_bit(state)) begin
                            bit_cnt_nxt = 6'd0;
                            state_nxt   = next_field(state);
                        end else begin
                            bit_cnt_nxt = bit_cnt + 6'd1;
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end

                // Sample in the first MDC-high cycle of the bit period.
                if (phy_mdc && (div_cnt == 8'd0) && !wr_q) begin
                    if ((state == TA) && bit_cnt[0]) begin
                        ta_err_nxt = phy_mdio_i;
                    end
                    if (state == DATA) begin
                        rd_sr_nxt = {rd_sr[14:0], phy_mdio_i};
                    end
                end
            end
        endcase

        // Publish the response as the frame enters DONE.
        if ((state == DATA) && (state_nxt == DONE)) begin
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = wr_q ? 16'h0000 : rd_sr_nxt;
            rsp_err_nxt   = wr_q ? 1'b0 : ta_err_nxt;
        end

        // Pad values are registered from the next field/bit, so they only
        // move on the edge that starts a new bit period.
        {mdio_oen_nxt, mdio_o_nxt} = drive_bit(state_nxt, bit_cnt_nxt[3:0],
                                               wr_nxt, phyad_nxt, regad_nxt,
                                               wdata_nxt);
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            bit_cnt      <= 6'd0;
            div_cnt      <= 8'd0;
            phy_mdc      <= 1'b0;
            phy_mdio_o   <= 1'b1;
            phy_mdio_oen <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'h0000;
            rsp_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            div_cnt      <= div_cnt_nxt;
            phy_mdc      <= mdc_nxt;
            phy_mdio_o   <= mdio_o_nxt;
            phy_mdio_oen <= mdio_oen_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_rdata    <= rsp_rdata_nxt;
            rsp_err      <= rsp_err_nxt;
        end
    end

    always_ff @(posedge msoc_clk) begin
        wr_q    <= wr_nxt;
        phyad_q <= phyad_nxt;
        regad_q <= regad_nxt;
        wdata_q <= wdata_nxt;
        rd_sr   <= rd_sr_nxt;
        ta_err  <= ta_err_nxt;
    end

endmodule

// File: tb/tb_eth_mdio_master.sv
// -----------------------------------------------------------------------------
// tb_eth_mdio_master
//
// Bench for eth_mdio_master. A frame-level model predicts every output of the
// preamble instance on every cycle; directed sequences cover write, read,
// missing PHY, reset abort, back-to-back requests and a preamble-less
// instance, with hand-computed literals for the serial bit patterns.
// -----------------------------------------------------------------------------
module tb_eth_mdio_master;

    localparam int CD = 2;
    localparam int L  = 64 * 2 * CD;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Preamble instance
    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_phyad, req_regad;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;
    logic        phy_mdc, phy_mdio_o, phy_mdio_oen;
    logic        phy_mdio_i = 1'b1;

    // Preamble-less instance
    logic        np_req_valid, np_req_ready, np_req_write;
    logic [4:0]  np_req_phyad, np_req_regad;
    logic [15:0] np_req_wdata;
    logic        np_rsp_valid, np_rsp_err, np_busy;
    logic [15:0] np_rsp_rdata;
    logic        np_mdc, np_mdio_o, np_mdio_oen;
    logic        np_mdio_i = 1'b1;

    eth_mdio_master #(.CLK_DIV(CD), .PREAMBLE_EN(1'b1)) dut (
        .msoc_clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_phyad(req_phyad), .req_regad(req_regad), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .phy_mdc(phy_mdc), .phy_mdio_o(phy_mdio_o),
        .phy_mdio_oen(phy_mdio_oen), .phy_mdio_i(phy_mdio_i)
    );

    eth_mdio_master #(.CLK_DIV(CD), .PREAMBLE_EN(1'b0)) dut_np (
        .msoc_clk(clk), .rstn(rstn),
        .req_valid(np_req_valid), .req_ready(np_req_ready), .req_write(np_req_write),
        .req_phyad(np_req_phyad), .req_regad(np_req_regad), .req_wdata(np_req_wdata),
        .rsp_valid(np_rsp_valid), .rsp_rdata(np_rsp_rdata), .rsp_err(np_rsp_err),
        .busy(np_busy), .phy_mdc(np_mdc), .phy_mdio_o(np_mdio_o),
        .phy_mdio_oen(np_mdio_oen), .phy_mdio_i(np_mdio_i)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- frame-level model ----------------
    // What the PHY model answers on the next read frame.
    logic [15:0] phy_data = 16'hFFFF;
    logic        phy_ta2  = 1'b1;

    bit          m_active = 1'b0;
    int          m_k      = 0;       // cycle index relative to acceptance
    bit          m_wr;
    logic [63:0] m_o, m_oen, m_phy;  // one bit per bit period, first bit at [63]
    logic [31:0] m_frame;
    logic [15:0] m_rdata = 16'h0, m_new_rdata;
    logic        m_err = 1'b0, m_new_err;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 1'b0;
            m_k      = 0;
            m_rdata  = 16'h0;
            m_err    = 1'b0;
        end else if (!m_active) begin
            if (req_valid) begin
                m_active = 1'b1;
                m_k      = 1;
                m_wr     = req_write;
                m_frame  = {2'b01, (req_write ? 2'b01 : 2'b10), req_phyad, req_regad,
                            (req_write ? 2'b10 : 2'b11), (req_write ? req_wdata : 16'hFFFF)};
                m_o      = {32'hFFFF_FFFF, m_frame};
                m_oen    = req_write ? 64'hFFFF_FFFF_FFFF_FFFF : {{46{1'b1}}, {18{1'b0}}};
                m_phy    = {{46{1'b1}}, 1'b1, phy_ta2, phy_data};
                m_new_rdata = req_write ? 16'h0 : phy_data;
                m_new_err   = req_write ? 1'b0 : phy_ta2;
            end
        end else if (m_k == L + 1) begin
            m_active = 1'b0;
        end else begin
            m_k++;
            if (m_k == L + 1) begin
                m_rdata = m_new_rdata;
                m_err   = m_new_err;
            end
        end
    end

    // ---------------- per-cycle compare + PHY drive + observers ----------------
    logic        e_ready, e_mdc, e_o, e_oen, e_valid, e_err;
    logic [15:0] e_rdata;
    int          e_idx, e_ph;
    logic        prev_mdc = 1'b0;
    logic [63:0] obs_o = 64'h0, obs_oen = 64'h0;
    int          rises = 0;
    int          rsp_cnt = 0;

    always @(negedge clk) begin
        e_idx = 0;
        if (!m_active) begin
            e_ready = 1'b1; e_mdc = 1'b0; e_o = 1'b1; e_oen = 1'b0; e_valid = 1'b0;
            e_rdata = m_rdata; e_err = m_err;
        end else if (m_k <= L) begin
            e_idx   = (m_k - 1) / (2 * CD);
            e_ph    = (m_k - 1) % (2 * CD);
            e_ready = 1'b0; e_mdc = (e_ph >= CD);
            e_o     = m_o[63 - e_idx]; e_oen = m_oen[63 - e_idx];
            e_valid = 1'b0; e_rdata = m_rdata; e_err = m_err;
        end else begin
            e_ready = 1'b0; e_mdc = 1'b0; e_o = 1'b1; e_oen = 1'b0; e_valid = 1'b1;
            e_rdata = m_rdata; e_err = m_err;
        end
        check("cyc_req_ready", 64'(req_ready), 64'(e_ready));
        check("cyc_busy", 64'(busy), 64'(!e_ready));
        check("cyc_mdc", 64'(phy_mdc), 64'(e_mdc));
        check("cyc_mdio_o", 64'(phy_mdio_o), 64'(e_o));
        check("cyc_mdio_oen", 64'(phy_mdio_oen), 64'(e_oen));
        check("cyc_rsp_valid", 64'(rsp_valid), 64'(e_valid));
        check("cyc_rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
        check("cyc_rsp_err", 64'(rsp_err), 64'(e_err));

        if (phy_mdc && !prev_mdc) begin
            obs_o   = {obs_o[62:0], phy_mdio_o};
            obs_oen = {obs_oen[62:0], phy_mdio_oen};
            rises++;
        end
        prev_mdc = phy_mdc;
        if (rsp_valid) rsp_cnt++;

        if (m_active && !m_wr && (m_k <= L)) phy_mdio_i = m_phy[63 - e_idx];
        else                                 phy_mdio_i = 1'b1;
    end

    logic        np_prev = 1'b0;
    logic [63:0] np_obs = 64'h0;
    int          np_rises = 0;
    always @(negedge clk) begin
        if (np_mdc && !np_prev) begin
            np_obs = {np_obs[62:0], np_mdio_o};
            np_rises++;
        end
        np_prev = np_mdc;
    end

    // ---------------- directed sequences ----------------
    task automatic issue(input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, output int t_acc);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_phyad = pa; req_regad = ra; req_wdata = wd;
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input int t_acc, input int lat);
        int t_seen;
        t_seen = -1;
        for (int i = 0; i < 1000 && t_seen < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) t_seen = cyc;
        end
        check(nm, 64'(t_seen - t_acc), 64'(lat));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, 64'(req_ready), 64'(1));
        check({pfx, "_busy"}, 64'(busy), 64'(0));
        check({pfx, "_mdc"}, 64'(phy_mdc), 64'(0));
        check({pfx, "_oen"}, 64'(phy_mdio_oen), 64'(0));
        check({pfx, "_o"}, 64'(phy_mdio_o), 64'(1));
        check({pfx, "_valid"}, 64'(rsp_valid), 64'(0));
        check({pfx, "_rdata"}, 64'(rsp_rdata), 64'(0));
        check({pfx, "_err"}, 64'(rsp_err), 64'(0));
    endtask

    initial begin
        int t0, t1, r0, c0, np_r0, found;
        req_valid = 1'b0; req_write = 1'b0; req_phyad = 5'd0; req_regad = 5'd0; req_wdata = 16'h0;
        np_req_valid = 1'b0; np_req_write = 1'b0; np_req_phyad = 5'd0; np_req_regad = 5'd0;
        np_req_wdata = 16'h0;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Write phyad=1 regad=0 wdata=1140
        r0 = rises;
        issue(1'b1, 5'd1, 5'd0, 16'h1140, t0);
        wait_rsp("wr_latency", t0, 257);
        check("wr_err", 64'(rsp_err), 64'(0));
        check("wr_rdata", 64'(rsp_rdata), 64'(0));
        check("wr_bits", obs_o, 64'hFFFF_FFFF_5082_1140);
        check("wr_oen", obs_oen, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wr_mdc_periods", 64'(rises - r0), 64'(64));

        // Read phyad=3 regad=2, PHY answers 0141 with TA low
        repeat (2) @(negedge clk);
        phy_data = 16'h0141; phy_ta2 = 1'b0;
        issue(1'b0, 5'd3, 5'd2, 16'h0000, t0);
        wait_rsp("rd_latency", t0, 257);
        check("rd_rdata", 64'(rsp_rdata), 64'h0141);
        check("rd_err", 64'(rsp_err), 64'(0));
        check("rd_bits", obs_o, 64'hFFFF_FFFF_618B_FFFF);
        check("rd_oen", obs_oen, 64'hFFFF_FFFF_FFFC_0000);

        // Read with no PHY: pad stays high
        repeat (2) @(negedge clk);
        phy_data = 16'hFFFF; phy_ta2 = 1'b1;
        c0 = rsp_cnt;
        issue(1'b0, 5'h1F, 5'h1F, 16'h1234, t0);
        wait_rsp("nophy_latency", t0, 257);
        check("nophy_rdata", 64'(rsp_rdata), 64'hFFFF);
        check("nophy_err", 64'(rsp_err), 64'(1));
        repeat (4) @(negedge clk);
        check("nophy_pulses", 64'(rsp_cnt - c0), 64'(1));
        check("nophy_held_rdata", 64'(rsp_rdata), 64'hFFFF);
        check("nophy_held_err", 64'(rsp_err), 64'(1));

        // Reset during DATA bit 5 of a write, MDC high
        c0 = rsp_cnt;
        issue(1'b1, 5'd4, 5'd6, 16'h0000, t0);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (m_active && m_k == 53 * 4 + 4) found = 1;
        end
        check("abort_reached", 64'(found), 64'(1));
        check("abort_pre_mdc", 64'(phy_mdc), 64'(1));
        check("abort_pre_oen", 64'(phy_mdio_oen), 64'(1));
        check("abort_pre_o", 64'(phy_mdio_o), 64'(0));
        #2 rstn = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_cnt - c0), 64'(0));
        phy_data = 16'h2468; phy_ta2 = 1'b0;
        issue(1'b0, 5'd3, 5'd2, 16'h0000, t0);
        wait_rsp("post_abort_latency", t0, 257);
        check("post_abort_rdata", 64'(rsp_rdata), 64'h2468);
        check("post_abort_err", 64'(rsp_err), 64'(0));

        // Preamble-less instance write
        np_r0 = np_rises;
        @(negedge clk);
        np_req_valid = 1'b1; np_req_write = 1'b1; np_req_phyad = 5'h1F;
        np_req_regad = 5'h10; np_req_wdata = 16'hA5C3;
        t0 = cyc;
        @(negedge clk);
        np_req_valid = 1'b0;
        t1 = -1;
        for (int i = 0; i < 400 && t1 < 0; i++) begin
            @(negedge clk);
            if (np_rsp_valid) t1 = cyc;
        end
        check("np_latency", 64'(t1 - t0), 64'(129));
        check("np_first_bits", 64'(np_obs[31:30]), 64'(2'b01));
        check("np_bits", 64'(np_obs[31:0]), 64'h5FC2_A5C3);
        check("np_mdc_periods", 64'(np_rises - np_r0), 64'(32));
        check("np_rdata", 64'(np_rsp_rdata), 64'(0));
        check("np_err", 64'(np_rsp_err), 64'(0));
        check("np_ready_done", 64'(np_req_ready), 64'(0));
        @(negedge clk);
        check("np_ready_idle", 64'(np_req_ready), 64'(1));

        // req_valid held through a frame, fields changed while busy
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_phyad = 5'd2; req_regad = 5'd4; req_wdata = 16'h00FF;
        t0 = cyc;
        @(negedge clk);
        req_phyad = 5'h0A; req_regad = 5'h15; req_wdata = 16'hBEEF;
        wait_rsp("hold_first_latency", t0, 257);
        check("hold_first_bits", obs_o, 64'hFFFF_FFFF_5112_00FF);
        check("hold_done_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        t1 = cyc;
        check("hold_idle_ready", 64'(req_ready), 64'(1));
        check("hold_second_accept", 64'(t1 - t0), 64'(258));
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("hold_second_latency", t1, 257);
        check("hold_second_bits", obs_o, 64'hFFFF_FFFF_5556_BEEF);
        check("hold_second_err", 64'(rsp_err), 64'(0));
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
